// File: rtl/phase1_pkg.sv
// Shared encodings and sizes for the minterm finder.
// State codes are fixed: IDLE=0, SCAN=1, EMIT=2, DONE=3.
package phase1_pkg;

  localparam int ROW_W = 4;
  localparam int ROWS  = 16;
  localparam int CNT_W = 5;

  typedef logic [1:0]       state_t;
  typedef logic [1:0]       pair_t;
  typedef logic [ROW_W-1:0] row_t;
  typedef logic [CNT_W-1:0] cnt_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_SCAN = 2'd1;
  localparam state_t ST_EMIT = 2'd2;
  localparam state_t ST_DONE = 2'd3;

  localparam row_t LAST_ROW = row_t'(ROWS - 1);

  // A row is reported only when its {f9,f8} pair equals the target and it is enabled.
  function automatic logic row_hit(input pair_t pair, input pair_t target, input logic en);
    return en && (pair == target);
  endfunction

endpackage

// File: rtl/minterm_finder_truth_eval.sv
// Combinational truth-table lookup: row {w,x,y,z} -> {f9,f8}.
module truth_eval
  import phase1_pkg::*;
#(
  parameter logic [ROWS-1:0] F8_ON = 16'h32FC,
  parameter logic [ROWS-1:0] F9_ON = 16'hB6A4
) (
  input  logic [ROW_W-1:0] i_row,
  output logic [1:0]       o_pair
);

  assign o_pair = {F9_ON[i_row], F8_ON[i_row]};

endmodule

// File: rtl/minterm_finder.sv
// Scans all 16 rows of f8/f9 and reports, in ascending order, every enabled row
// whose {f9,f8} pair equals the requested target, then pulses done with the count.
//
// state | meaning
// IDLE  | ready for a request
// SCAN  | evaluating row r_row_cnt, one row per cycle
// EMIT  | holding out_row/out_valid until the consumer takes it
// DONE  | one-cycle done pulse with final match_count
module minterm_finder
  import phase1_pkg::*;
#(
  parameter logic [ROWS-1:0] F8_ON = 16'h32FC,
  parameter logic [ROWS-1:0] F9_ON = 16'hB6A4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [1:0]       req_target,
  input  logic [ROWS-1:0]  req_mask,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ROW_W-1:0] out_row,
  output logic             done,
  output logic [CNT_W-1:0] match_count,
  output logic             busy
);

  state_t           r_state;
  row_t             r_row_cnt;
  pair_t            r_target;
  logic [ROWS-1:0]  r_mask;
  row_t             r_out_row;
  cnt_t             r_match_cnt;

  pair_t            w_pair;
  logic             w_hit;
  logic             w_last;

  truth_eval #(
    .F8_ON (F8_ON),
    .F9_ON (F9_ON)
  ) u_truth_eval (
    .i_row  (r_row_cnt),
    .o_pair (w_pair)
  );

  assign w_hit  = row_hit(w_pair, r_target, r_mask[r_row_cnt]);
  assign w_last = (r_row_cnt == LAST_ROW);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_row_cnt   <= '0;
      r_target    <= '0;
      r_mask      <= '0;
      r_out_row   <= '0;
      r_match_cnt <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (req_valid) begin
            r_target    <= req_target;
            r_mask      <= req_mask;
            r_row_cnt   <= '0;
            r_match_cnt <= '0;
            r_state     <= ST_SCAN;
          end
        end
        ST_SCAN: begin
          if (w_hit) begin
            r_out_row <= r_row_cnt;
            r_state   <= ST_EMIT;
          end else if (w_last) begin
            r_state   <= ST_DONE;
          end else begin
            r_row_cnt <= r_row_cnt + row_t'(1);
          end
        end
        ST_EMIT: begin
          // r_row_cnt still points at the emitted row while we wait here.
          if (out_ready) begin
            r_match_cnt <= r_match_cnt + cnt_t'(1);
            if (w_last) begin
              r_state   <= ST_DONE;
            end else begin
              r_row_cnt <= r_row_cnt + row_t'(1);
              r_state   <= ST_SCAN;
            end
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  // Handshake outputs decode the state register only, so out_ready never reaches out_valid.
  assign req_ready   = (r_state == ST_IDLE);
  assign busy        = (r_state != ST_IDLE);
  assign out_valid   = (r_state == ST_EMIT);
  assign done        = (r_state == ST_DONE);
  assign out_row     = r_out_row;
  assign match_count = r_match_cnt;

endmodule

// File: tb/tb_minterm_finder.sv
// Directed bench for minterm_finder: hand-derived row lists per target/mask,
// back-pressure, ignored mid-scan requests and reset during EMIT.
module tb_minterm_finder;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_target;
  logic [15:0] req_mask;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  out_row;
  logic        done;
  logic [4:0]  match_count;
  logic        busy;

  int total = 0;
  int bad   = 0;
  int exp_q[$];

  minterm_finder dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_target  (req_target),
    .req_mask    (req_mask),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_row     (out_row),
    .done        (done),
    .match_count (match_count),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  // Issues one request and scoreboards the emitted rows against exp_q.
  // stall > 0 holds out_ready low for that many cycles on the first hit.
  // poke_mid pulses req_valid while the scan is running.
  task automatic run(input logic [1:0] target, input logic [15:0] mask,
                     input int stall, input bit poke_mid);
    int idx = 0;
    int cyc = 0;
    int held = 0;
    bit got_done = 0;
    int exp_cyc;
    exp_cyc = 16 + exp_q.size() + ((stall > 0) ? stall - 1 : 0);
    @(negedge clk);
    req_valid  = 1'b1;
    req_target = target;
    req_mask   = mask;
    out_ready  = (stall == 0);
    @(negedge clk);
    req_valid  = 1'b0;
    chk("accept_busy", busy, 1);
    chk("accept_ready", req_ready, 0);
    while (!got_done && cyc < 100) begin
      @(negedge clk);
      cyc++;
      if (poke_mid) begin
        req_valid = (cyc == 3);
        req_target = ~target;
      end
      if (out_valid && out_ready) begin
        chk("row", out_row, (idx < exp_q.size()) ? exp_q[idx] : 99);
        idx++;
      end else if (out_valid) begin
        if (held == 0) begin
          chk("row", out_row, (idx < exp_q.size()) ? exp_q[idx] : 99);
          idx++;
        end else begin
          chk("hold_row", out_row, exp_q[idx-1]);
        end
        held++;
        if (held == stall) out_ready = 1'b1;
      end
      if (done) begin
        got_done = 1;
        chk("count", match_count, exp_q.size());
        chk("nrows", idx, exp_q.size());
        chk("done_cycle", cyc, exp_cyc);
      end
    end
    req_valid = 1'b0;
    if (!got_done) chk("done_timeout", 0, 1);
    if (stall > 0) chk("held_cycles", held, stall);
    @(negedge clk);
    chk("done_one_cycle", done, 0);
    chk("idle_ready", req_ready, 1);
    chk("idle_busy", busy, 0);
    out_ready = 1'b1;
  endtask

  initial begin
    bit reached;
    rst        = 1'b1;
    req_valid  = 1'b0;
    req_target = 2'b00;
    req_mask   = 16'h0000;
    out_ready  = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_ready", req_ready, 1);
    chk("rst_valid", out_valid, 0);
    chk("rst_done", done, 0);
    chk("rst_busy", busy, 0);
    chk("rst_row", out_row, 0);
    chk("rst_count", match_count, 0);

    exp_q = '{2, 5, 7, 9, 12, 13};
    run(2'b11, 16'hFFFF, 0, 0);

    exp_q = '{0, 1, 8, 11, 14};
    run(2'b00, 16'hFFFF, 0, 1);

    exp_q = '{10, 15};
    run(2'b10, 16'hFFFF, 0, 0);

    exp_q = '{4};
    run(2'b01, 16'hFFB7, 0, 0);

    exp_q = {};
    run(2'b01, 16'h0000, 0, 0);

    exp_q = '{15};
    run(2'b10, 16'h8000, 0, 0);

    exp_q = '{2, 5, 7, 9, 12, 13};
    run(2'b11, 16'hFFFF, 5, 0);

    // Reset while a row is held in EMIT.
    @(negedge clk);
    req_valid  = 1'b1;
    req_target = 2'b11;
    req_mask   = 16'hFFFF;
    out_ready  = 1'b0;
    @(negedge clk);
    req_valid = 1'b0;
    reached = 0;
    for (int i = 0; i < 20 && !reached; i++) begin
      @(negedge clk);
      if (out_valid) reached = 1;
    end
    chk("emit_reached", reached, 1);
    chk("emit_row", out_row, 2);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_emit_valid", out_valid, 0);
    chk("rst_emit_done", done, 0);
    chk("rst_emit_busy", busy, 0);
    rst = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    chk("rst_emit_ready", req_ready, 1);
    reached = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done || out_valid) reached = 1;
    end
    chk("no_done_after_rst", reached, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
